muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, beside the ALU; receives the same rs/rt operands.
- Owns the architectural HI/LO registers. Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises `busy` so the hazard unit stalls MFHI/MFLO and any new mul/div op until the result is ready.

Parameters:
- DATA_W, 32, operand and HI/LO width. Iteration count equals DATA_W.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- md_start  input  1  request strobe, sampled each cycle
- md_op  input  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NOP)
- md_a  input  DATA_W  rs operand (dividend / multiplicand / MTHI-MTLO source)
- md_b  input  DATA_W  rt operand (divisor / multiplier)
- md_flush  input  1  exception/branch kill of the in-flight op
- busy  output  1  high while an iterative op is in progress
- done  output  1  one-cycle pulse on the cycle HI/LO take a mul/div result
- hi  output  DATA_W  HI register
- lo  output  DATA_W  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. A reset asserted mid-operation aborts the op and applies these values on the next edge.
- FSM states: IDLE, MUL, DIV.
- Accept rule: a request is accepted only when state=IDLE, md_start=1 and md_flush=0.
  - md_start while busy is ignored; no queueing.
- MTHI / MTLO:
  - In IDLE, hi (or lo) <= md_a at the edge ending the accept cycle.
  - No busy, no done.
- MULT/MULTU, DIV/DIVU accept:
  - Latch |a| and |b| (signed ops) or raw a and b (unsigned ops).
  - Latch result-sign flags.
  - Go to MUL or DIV; counter=0.
- busy is combinationally (state != IDLE). It is high for exactly DATA_W cycles starting the cycle after accept.
- Each MUL/DIV cycle performs one iteration; the counter increments.
  - MUL: shift-add of one multiplier bit into a 2*DATA_W accumulator.
  - DIV: restoring radix-2 step, one quotient bit per cycle.
- Completion: on the edge ending iteration DATA_W, the state returns to IDLE and HI/LO load the sign-fixed result.
  - done=1 for the following cycle.
  - busy=0 in that same cycle, and new hi/lo are visible then.
  - Total: accept at cycle T gives results and done at cycle T+DATA_W+1.
- Multiply result: {hi,lo} = full 2*DATA_W product.
  - Signed: the product is negated when a[msb] XOR b[msb].
- Divide result: lo = quotient, hi = remainder.
  - Signed: the quotient is negated when signs differ; the remainder takes the dividend's sign.
- Divide by zero: full-length op, same timing; lo = all-ones, hi = md_a (original dividend).
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. Falls out of the magnitude arithmetic; must be verified.
- md_flush:
  - In MUL/DIV, the next state is IDLE, hi/lo are unchanged and there is no done pulse.
  - In IDLE, flush suppresses any accept that cycle (flush wins over start, including MTHI/MTLO).
- Operand registers are captured at accept. md_a/md_b changes during busy have no effect.
- hi/lo change only on MTHI/MTLO accept, mul/div completion, or reset.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU complete in a single cycle using a combinational product.
  - {hi,lo} loads at the edge ending the accept cycle, with done=1 the next cycle.
  - busy is never asserted for multiplies; the MUL state is unused.
  - Divide behaviour is unchanged.
- Undefined: multiplies use the iterative DATA_W-cycle path described above.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done one cycle. With MULDIV_FAST_MUL_EN: busy never high, result plus done one cycle after accept.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100 after 32 busy cycles. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x1234 then MTLO 0xABCD in consecutive cycles -> hi=0x1234 and lo=0xABCD one edge after each, busy stays 0, no done. A second md_start issued mid-DIV -> ignored, first result intact.
- DIVU 50/7 with md_flush pulsed at iteration 10 -> IDLE next cycle, busy=0, hi/lo retain prior values, no done. Start and flush in the same IDLE cycle -> no accept.
- rst asserted at iteration 20 of a MULTU -> next edge: hi=lo=0, busy=0, done=0. A fresh DIVU 9/4 then yields lo=2, hi=1.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divide stays iterative.
module muldiv_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              md_start,
  input  logic [2:0]        md_op,
  input  logic [DATA_W-1:0] md_a,
  input  logic [DATA_W-1:0] md_b,
  input  logic              md_flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic                neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d, done_q, done_d;

  logic                accept, op_signed, last;
  logic [DATA_W-1:0]   a_mag, b_mag, a_src, b_src;
  logic [DATA_W:0]     mul_sum, div_sh, div_diff;
  logic [2*DATA_W-1:0] mul_next, div_next;
  logic [DATA_W-1:0]   quot, rem;

  assign accept    = (state_q == S_IDLE) && md_start && !md_flush;
  assign op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
  assign a_mag     = md_a[DATA_W-1] ? -md_a : md_a;
  assign b_mag     = md_b[DATA_W-1] ? -md_b : md_b;
  assign a_src     = op_signed ? a_mag : md_a;
  assign b_src     = op_signed ? b_mag : md_b;
  assign last      = (cnt_q == CNT_W'(DATA_W - 1));

  // Multiply: acc = {partial product, unconsumed multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_next = {mul_sum, acc_q[DATA_W-1:1]};

  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}, shifted left.
  assign div_sh   = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
  assign div_diff = div_sh - {1'b0, b_q};
  assign div_next = div_diff[DATA_W] ? {div_sh[DATA_W-1:0],   acc_q[DATA_W-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
  assign quot     = div_next[DATA_W-1:0];
  assign rem      = div_next[2*DATA_W-1:DATA_W];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*DATA_W-1:0] prod_s, prod_u;
  assign prod_s = $signed({{DATA_W{md_a[DATA_W-1]}}, md_a}) *
                  $signed({{DATA_W{md_b[DATA_W-1]}}, md_b});
  assign prod_u = {{DATA_W{1'b0}}, md_a} * {{DATA_W{1'b0}}, md_b};
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (md_op)
`ifndef MULDIV_FAST_MUL_EN
            OP_MULT, OP_MULTU: state_d = S_MUL;
`endif
            OP_DIV, OP_DIVU:   state_d = S_DIV;
            default:           state_d = S_IDLE;
          endcase
        end
      end
      S_MUL, S_DIV: if (md_flush || last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (md_op)
            OP_MTHI: hi_d = md_a;
            OP_MTLO: lo_d = md_a;
            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
              {hi_d, lo_d} = op_signed ? prod_s : prod_u;
              done_d       = 1'b1;
`else
              a_d   = a_src;
              b_d   = b_src;
              acc_d = {{DATA_W{1'b0}}, b_src};
              neg_d = op_signed && (md_a[DATA_W-1] ^ md_b[DATA_W-1]);
              cnt_d = '0;
`endif
            end
            OP_DIV, OP_DIVU: begin
              // a_q keeps the raw dividend: only needed for the divide-by-zero result.
              a_d    = md_a;
              b_d    = b_src;
              acc_d  = {{DATA_W{1'b0}}, a_src};
              neg_d  = op_signed && (md_a[DATA_W-1] ^ md_b[DATA_W-1]);
              rneg_d = op_signed && md_a[DATA_W-1];
              dz_d   = (md_b == '0);
              cnt_d  = '0;
            end
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (md_flush) begin
          cnt_d = '0;
        end else begin
          acc_d = mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            {hi_d, lo_d} = neg_q ? -mul_next : mul_next;
            done_d       = 1'b1;
          end
        end
      end
      S_DIV: begin
        if (md_flush) begin
          cnt_d = '0;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (last) begin
            done_d = 1'b1;
            if (dz_q) begin
              lo_d = '1;
              hi_d = a_q;
            end else begin
              lo_d = neg_q  ? -quot : quot;
              hi_d = rneg_q ? -rem  : rem;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, md_start, md_flush;
  logic [2:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_WAIT = 0;
`else
  localparam int MUL_WAIT = 32;
`endif

  muldiv_unit #(.DATA_W(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .md_start(md_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .md_flush(md_flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} straight from integer arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb, q, r;
    longint      ps;
    logic [63:0] res;
    sa  = a;
    sb  = b;
    res = '0;
    case (op)
      3'd1: begin ps = longint'(sa) * longint'(sb); res = ps; end
      3'd2: res = 64'(a) * 64'(b);
      3'd3: begin
        if (b == 32'd0)                                     res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)    res = {32'h0, 32'h80000000};
        else begin q = sa / sb; r = sa % sb; res = {32'(r), 32'(q)}; end
      end
      3'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else            res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  int          rem_cyc = 0;
  logic [63:0] pend;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_done = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      rem_cyc = 0; m_hi = '0; m_lo = '0; m_done = 1'b0; chk_en = 1'b1;
    end else begin
      m_done = 1'b0;
      if (rem_cyc > 0) begin
        if (md_flush) rem_cyc = 0;
        else begin
          rem_cyc--;
          if (rem_cyc == 0) begin {m_hi, m_lo} = pend; m_done = 1'b1; end
        end
      end else if (md_start && !md_flush) begin
        case (md_op)
          3'd5: m_hi = md_a;
          3'd6: m_lo = md_a;
          3'd1, 3'd2: begin
            pend = ref_op(md_op, md_a, md_b);
`ifdef MULDIV_FAST_MUL_EN
            {m_hi, m_lo} = pend; m_done = 1'b1;
`else
            rem_cyc = 32;
`endif
          end
          3'd3, 3'd4: begin pend = ref_op(md_op, md_a, md_b); rem_cyc = 32; end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(rem_cyc > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start = 1'b1; md_op = op; md_a = a; md_b = b;
    @(negedge clk);
    md_start = 1'b0; md_op = 3'd0; md_a = $urandom; md_b = $urandom;
  endtask

  task automatic chk_res(input string nm, input logic [31:0] eh, input logic [31:0] el);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    chk({nm, "_done"}, 32'(done), 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; md_start = 1'b0; md_flush = 1'b0; md_op = '0; md_a = '0; md_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (MUL_WAIT) @(negedge clk);
    chk_res("multu", 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);

    issue(3'd1, 32'hFFFFFFFD, 32'd7);
    repeat (MUL_WAIT) @(negedge clk);
    chk_res("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    repeat (32) @(negedge clk);
    chk_res("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(3'd4, 32'd100, 32'd0);
    repeat (32) @(negedge clk);
    chk_res("divu0", 32'd100, 32'hFFFFFFFF);

    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    repeat (32) @(negedge clk);
    chk_res("divovf", 32'h0, 32'h80000000);

    issue(3'd5, 32'h1234, 32'h0);
    chk("mthi_hi", hi, 32'h1234);
    issue(3'd6, 32'hABCD, 32'h0);
    chk("mtlo_lo", lo, 32'hABCD);
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_done", 32'(done), 32'd0);

    issue(3'd4, 32'd50, 32'd7);
    repeat (4) @(negedge clk);
    issue(3'd2, 32'd3, 32'd3);
    repeat (27) @(negedge clk);
    chk_res("ignored", 32'd1, 32'd7);

    issue(3'd4, 32'd50, 32'd7);
    repeat (9) @(negedge clk);
    md_flush = 1'b1;
    @(negedge clk);
    md_flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", hi, 32'd1);
    chk("flush_lo", lo, 32'd7);
    repeat (25) @(negedge clk);
    chk("flush_nodone", 32'(done), 32'd0);

    md_flush = 1'b1;
    issue(3'd4, 32'd60, 32'd5);
    md_flush = 1'b0;
    chk("startflush_busy", 32'(busy), 32'd0);

    issue(3'd2, 32'd12345, 32'd678);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);

    issue(3'd4, 32'd9, 32'd4);
    repeat (32) @(negedge clk);
    chk_res("divu94", 32'd1, 32'd2);

    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 799) == 0);
      md_start = ($urandom_range(0, 3) == 0);
      md_op    = 3'($urandom_range(0, 7));
      md_a     = pick();
      md_b     = pick();
      md_flush = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    rst = 1'b0; md_start = 1'b0; md_flush = 1'b0;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
